thread_regfile: RTL and testbench
=================================

THREAD_REGFILE -- requirements
Module: thread_regfile

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4: block size, presented read-only in R14.
REQ-002 Parameter THREAD_ID, default 0: this thread's index, presented read-only in R15.
REQ-003 Parameter DATA_BITS, default 8: register and operand width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  thread active; low freezes all state and outputs.
REQ-007 block_id  input  8  current block index, mirrored into R13.
REQ-008 core_state  input  3  core phase: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
REQ-009 decoded_rs_address  input  4  first source register index.
REQ-010 decoded_rt_address  input  4  second source register index.
REQ-011 decoded_rd_address  input  4  destination register index.
REQ-012 decoded_reg_write_enable  input  1  instruction writes rd.
REQ-013 decoded_reg_input_mux  input  2  write source: 00 ALU, 01 MEMORY, 10 CONSTANT, 11 reserved.
REQ-014 decoded_immediate  input  8  constant for CONSTANT writes.
REQ-015 alu_out  input  8  result from this thread's ALU.
REQ-016 lsu_out  input  8  load data from this thread's LSU.
REQ-017 rs  output  8  registered first operand to the ALU/LSU.
REQ-018 rt  output  8  registered second operand to the ALU/LSU.

Function
REQ-019 Storage SHALL be 16 registers x DATA_BITS; R0-R12 general purpose, R13-R15 read-only.
REQ-020 R14 SHALL always read THREADS_PER_BLOCK and R15 SHALL always read THREAD_ID, truncated to DATA_BITS.
REQ-021 On every rising edge with enable=1 and reset=0, R13 SHALL load block_id, regardless of core_state.
REQ-022 When enable=1 and core_state=REQUEST, rs SHALL load reg[decoded_rs_address] and rt SHALL load reg[decoded_rt_address] at that edge; values are valid from the following cycle (WAIT) onward.
REQ-023 rs and rt SHALL hold their values in every state other than REQUEST, so operands stay stable through WAIT and EXECUTE.
REQ-024 rs_address equal to rt_address SHALL return the same value on both outputs.
REQ-025 When enable=1, core_state=UPDATE, decoded_reg_write_enable=1 and decoded_rd_address<=12, the write SHALL take effect at that edge.
REQ-026 The written value SHALL be alu_out for mux 00, lsu_out for mux 01, and decoded_immediate for mux 10.
REQ-027 Mux value 11 SHALL perform no write.
REQ-028 Writes addressed to R13-R15 SHALL be silently discarded; no other register changes.
REQ-029 A write SHALL be visible to a read issued in any later REQUEST cycle; reads and writes never share a cycle because REQUEST and UPDATE are distinct states.
REQ-030 With enable=0, no register, rs or rt SHALL change, including R13.
REQ-031 Latency: operand read is 1 cycle (REQUEST edge to valid output); write is 1 cycle (UPDATE edge).
REQ-032 The block SHALL have no combinational path from any input to rs or rt.

Reset
REQ-033 With reset=1 at a rising edge, R0-R13, rs and rt SHALL be cleared to 0, regardless of enable.
REQ-034 R14 and R15 SHALL read their parameter values during and immediately after reset.
REQ-035 Reset asserted in REQUEST or UPDATE SHALL take priority and discard the pending read or write.

Verification
REQ-036 Reset, then REQUEST with rs_addr=14 and rt_addr=15 (THREADS_PER_BLOCK=4, THREAD_ID=2) -> next cycle rs=4, rt=2.
REQ-037 UPDATE with rd=3, mux=10, imm=0x5A, then REQUEST with rs_addr=3 -> rs=0x5A; UPDATE with rd=3, mux=00, alu_out=0x11 -> a later read returns 0x11.
REQ-038 UPDATE with rd=13, mux=01, lsu_out=0xFF while block_id=0x07 -> R13 reads 0x07; R0-R12 are unchanged.
REQ-039 enable=0 during UPDATE with rd=5, imm=0x33, and during a REQUEST -> R5 stays 0 and rs/rt hold their previous values.
REQ-040 Reset asserted in UPDATE with rd=2, imm=0x44 -> R2=0, rs=0, rt=0; mux=11 in UPDATE with rd=4 -> R4 unchanged.

Source files
------------

// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13 mirrors block_id,
// R14/R15 read back the block size and thread index parameters.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   enable            thread active; low freezes all state
//   block_id          mirrored into R13 on every enabled edge
//   core_state        core phase (REQUEST reads, UPDATE writes)
//   decoded_*         register addresses, write enable, write source, imm
//   alu_out, lsu_out  write-back sources
//   rs, rt            registered operands to the ALU/LSU
module thread_regfile #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic [3:0]           decoded_rd_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [7:0]           decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  localparam logic [DATA_BITS-1:0] TPB_C =
    DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] TID_C =
    DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] regs_q [14];
  logic [DATA_BITS-1:0] regs_d [14];
  logic [DATA_BITS-1:0] rs_q, rs_d;
  logic [DATA_BITS-1:0] rt_q, rt_d;

  logic [DATA_BITS-1:0] view [16];
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_src_ok;
  logic                 wr_en;

  // R14/R15 are constants, not storage.
  always_comb begin
    for (int i = 0; i < 14; i++) begin
      view[i] = regs_q[i];
    end
    view[14] = TPB_C;
    view[15] = TID_C;
  end

  always_comb begin
    wr_data   = '0;
    wr_src_ok = 1'b1;
    case (decoded_reg_input_mux)
      2'b00:   wr_data = alu_out;
      2'b01:   wr_data = lsu_out;
      2'b10:   wr_data = DATA_BITS'(decoded_immediate);
      default: wr_src_ok = 1'b0;
    endcase
  end

  assign wr_en = enable
               && (core_state == ST_UPDATE)
               && decoded_reg_write_enable
               && wr_src_ok
               && (decoded_rd_address <= 4'd12);

  always_comb begin
    regs_d = regs_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    if (enable) begin
      regs_d[13] = DATA_BITS'(block_id);
      if (core_state == ST_REQUEST) begin
        rs_d = view[decoded_rs_address];
        rt_d = view[decoded_rt_address];
      end
    end
    for (int i = 0; i < 13; i++) begin
      if (wr_en && (decoded_rd_address == 4'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 14; i++) begin
        regs_q[i] <= '0;
      end
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      regs_q <= regs_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
    end
  end

  assign rs = rs_q;
  assign rt = rt_q;

endmodule

// File: tb/tb_thread_regfile.sv
// Directed table-driven bench for thread_regfile
// (THREADS_PER_BLOCK=4, THREAD_ID=2, DATA_BITS=8).
module tb_thread_regfile;

  localparam logic [2:0] IDL = 3'b000;
  localparam logic [2:0] WAI = 3'b100;
  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic [3:0] rs_a, rt_a, rd_a;
  logic       we;
  logic [1:0] mux;
  logic [7:0] imm, alu, lsu;
  logic [7:0] rs, rt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thread_regfile #(
    .THREADS_PER_BLOCK(4),
    .THREAD_ID(2),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .block_id(block_id),
    .core_state(core_state),
    .decoded_rs_address(rs_a),
    .decoded_rt_address(rt_a),
    .decoded_rd_address(rd_a),
    .decoded_reg_write_enable(we),
    .decoded_reg_input_mux(mux),
    .decoded_immediate(imm),
    .alu_out(alu),
    .lsu_out(lsu),
    .rs(rs),
    .rt(rt)
  );

  typedef struct {
    bit         rst;
    bit         en;
    logic [2:0] st;
    logic [3:0] ra, rb, rd;
    bit         w;
    logic [1:0] mx;
    logic [7:0] imm, alu, lsu, blk;
    logic [7:0] ers, ert;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    bit rst_, bit en_, logic [2:0] st_,
    logic [3:0] ra_, logic [3:0] rb_, logic [3:0] rd_,
    bit w_, logic [1:0] mx_,
    logic [7:0] imm_, logic [7:0] alu_, logic [7:0] lsu_,
    logic [7:0] blk_, logic [7:0] ers_, logic [7:0] ert_);
    vec_t t;
    t.rst = rst_; t.en = en_; t.st = st_;
    t.ra = ra_; t.rb = rb_; t.rd = rd_;
    t.w = w_; t.mx = mx_;
    t.imm = imm_; t.alu = alu_; t.lsu = lsu_; t.blk = blk_;
    t.ers = ers_; t.ert = ert_;
    return t;
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t t, bit chk, string tag);
    reset      = t.rst;
    enable     = t.en;
    core_state = t.st;
    rs_a = t.ra; rt_a = t.rb; rd_a = t.rd;
    we = t.w; mux = t.mx;
    imm = t.imm; alu = t.alu; lsu = t.lsu;
    block_id = t.blk;
    @(posedge clk);
    #1;
    if (chk) begin
      check({tag, ".rs"}, rs, t.ers);
      check({tag, ".rt"}, rt, t.ert);
    end
  endtask

  initial begin
    //          rst en st   ra  rb  rd  w  mx    imm    alu    lsu    blk    rs     rt
    vecs.push_back(v(1,1,IDL, 0, 0, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h00,8'h00));
    vecs.push_back(v(0,1,REQ,14,15, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h04,8'h02));
    vecs.push_back(v(0,1,WAI, 0, 0, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h04,8'h02));
    vecs.push_back(v(0,1,UPD, 0, 0, 3,1,2'b10,8'h5A,8'h00,8'h00,8'h07,8'h04,8'h02));
    vecs.push_back(v(0,1,REQ, 3, 3, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h5A,8'h5A));
    vecs.push_back(v(0,1,UPD, 0, 0, 3,1,2'b00,8'h00,8'h11,8'h00,8'h07,8'h5A,8'h5A));
    vecs.push_back(v(0,1,REQ, 3,13, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h11,8'h07));
    vecs.push_back(v(0,1,UPD, 0, 0,13,1,2'b01,8'h00,8'h00,8'hFF,8'h07,8'h11,8'h07));
    vecs.push_back(v(0,1,REQ,13, 0, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h07,8'h00));
    vecs.push_back(v(0,1,UPD, 0, 0, 1,1,2'b01,8'h00,8'h00,8'hA5,8'h07,8'h07,8'h00));
    vecs.push_back(v(0,1,REQ, 1,12, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'hA5,8'h00));
    vecs.push_back(v(0,1,UPD, 0, 0, 4,1,2'b11,8'h99,8'h99,8'h99,8'h07,8'hA5,8'h00));
    vecs.push_back(v(0,1,REQ, 4, 1, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h00,8'hA5));
    vecs.push_back(v(0,0,UPD, 0, 0, 5,1,2'b10,8'h33,8'h00,8'h00,8'h07,8'h00,8'hA5));
    vecs.push_back(v(0,0,REQ,14,15, 0,0,2'b00,8'h00,8'h00,8'h00,8'h07,8'h00,8'hA5));
    vecs.push_back(v(0,0,IDL, 0, 0, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h00,8'hA5));
    vecs.push_back(v(0,1,REQ, 5,13, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h00,8'h07));
    vecs.push_back(v(0,1,REQ,13,13, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h3C,8'h3C));
    vecs.push_back(v(0,1,UPD, 0, 0, 2,1,2'b10,8'h44,8'h00,8'h00,8'h3C,8'h3C,8'h3C));
    vecs.push_back(v(0,1,REQ, 2, 2, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h44,8'h44));
    vecs.push_back(v(1,1,UPD, 0, 0, 2,1,2'b10,8'h77,8'h00,8'h00,8'h3C,8'h00,8'h00));
    vecs.push_back(v(0,1,REQ, 2,13, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h00,8'h00));
    vecs.push_back(v(1,1,REQ,14,15, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h00,8'h00));
    vecs.push_back(v(0,1,REQ,14,15, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h04,8'h02));
    vecs.push_back(v(1,0,IDL, 0, 0, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h00,8'h00));
    vecs.push_back(v(0,1,UPD, 0, 0, 0,1,2'b00,8'h00,8'hC3,8'h00,8'h3C,8'h00,8'h00));
    vecs.push_back(v(0,1,REQ, 0, 3, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'hC3,8'h00));
    vecs.push_back(v(0,1,UPD, 0, 0,15,1,2'b10,8'hEE,8'h00,8'h00,8'h3C,8'hC3,8'h00));
    vecs.push_back(v(0,1,UPD, 0, 0,14,1,2'b10,8'hEE,8'h00,8'h00,8'h3C,8'hC3,8'h00));
    vecs.push_back(v(0,1,REQ,15,14, 0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,8'h02,8'h04));

    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Fill R0-R12 with distinct constants, hit R13 with a load,
    // then read every pair back to prove nothing else moved.
    for (int i = 0; i < 13; i++) begin
      drive(v(0,1,UPD,0,0,4'(i),1,2'b10,8'(8'h20 + i),
              8'h00,8'h00,8'h3C,8'h00,8'h00), 1'b0, "fill");
    end
    drive(v(0,1,UPD,0,0,13,1,2'b01,8'h00,8'h00,8'hFF,8'h3C,
            8'h00,8'h00), 1'b0, "r13w");
    for (int i = 0; i < 13; i++) begin
      drive(v(0,1,REQ,4'(i),4'(12 - i),0,0,2'b00,8'h00,8'h00,
              8'h00,8'h3C,8'(8'h20 + i),8'(8'h20 + 12 - i)),
            1'b1, $sformatf("sweep%0d", i));
    end
    drive(v(0,1,REQ,13,13,0,0,2'b00,8'h00,8'h00,8'h00,8'h3C,
            8'h3C,8'h3C), 1'b1, "r13hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
